// File: rtl/lock_pkg.sv
// Shared definitions for the carrier lock detector: df width and lock-state encoding.
package lock_pkg;

  localparam int DF_W   = 28;
  localparam int SPAN_W = DF_W + 1;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/win_span.sv
// Window sample counter with running signed min/max of df and a registered
// max-min span that is published once per completed window.
module win_span
  import lock_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic signed [DF_W-1:0]   df,
  output logic        [SPAN_W-1:0] span,
  output logic                     span_valid,
  output logic                     win_end,
  output logic        [SPAN_W-1:0] span_nxt
);

  logic        [WIN_LOG2-1:0] cnt_p0;
  logic signed [DF_W-1:0]     min_p0;
  logic signed [DF_W-1:0]     max_p0;
  logic signed [DF_W-1:0]     min_nxt;
  logic signed [DF_W-1:0]     max_nxt;
  logic                       first_smp;
  logic        [SPAN_W-1:0]   span_p1;
  logic                       vld_p1;

  // Sign-extending both operands by one bit makes the full df range exact;
  // hi >= lo always holds, so the modulo-2^29 difference is the true span.
  function automatic logic [SPAN_W-1:0] span_of(input logic signed [DF_W-1:0] hi,
                                                input logic signed [DF_W-1:0] lo);
    return {hi[DF_W-1], hi} - {lo[DF_W-1], lo};
  endfunction

  // Next min/max including the current sample; the first sample of a window seeds both.
  always_comb begin
    first_smp = (cnt_p0 == '0);
    win_end   = clken && (&cnt_p0);
    min_nxt   = (first_smp || (df < min_p0)) ? df : min_p0;
    max_nxt   = (first_smp || (df > max_p0)) ? df : max_p0;
    span_nxt  = span_of(max_nxt, min_nxt);
  end

  // ---- stage p0: window accumulation, frozen while clken is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0 <= '0;
      min_p0 <= '0;
      max_p0 <= '0;
    end else if (clken) begin
      cnt_p0 <= cnt_p0 + WIN_LOG2'(1);
      min_p0 <= min_nxt;
      max_p0 <= max_nxt;
    end
  end

  // ---- stage p1: span register and its one-cycle valid strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      span_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= win_end;
      if (win_end) span_p1 <= span_nxt;
    end
  end

  assign span       = span_p1;
  assign span_valid = vld_p1;

endmodule

// File: rtl/lock_detect.sv
// Carrier lock detector: classifies each window's df span as good/neutral/bad
// and runs a hysteretic UNLOCK/ACQ/LOCKED state machine at window end.
module lock_detect
  import lock_pkg::*;
#(
  parameter int              WIN_LOG2   = 10,
  parameter logic [SPAN_W-1:0] LOCK_THR   = 29'd4096,
  parameter logic [SPAN_W-1:0] UNLOCK_THR = 29'd16384,
  parameter int              LOCK_WINS  = 4,
  parameter int              LOSS_WINS  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic signed [DF_W-1:0]   df,
  output logic        [SPAN_W-1:0] span,
  output logic                     span_valid,
  output logic        [1:0]        lock_state,
  output logic                     locked
);

  logic              win_end;
  logic [SPAN_W-1:0] span_nxt;
  logic              good;
  logic              bad;
  logic [3:0]        good_inc;
  logic [3:0]        loss_inc;
  lock_state_t       state_p1;
  logic [3:0]        good_cnt_p1;
  logic [3:0]        loss_cnt_p1;
  logic              locked_p1;

  win_span #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_span (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .df         (df),
    .span       (span),
    .span_valid (span_valid),
    .win_end    (win_end),
    .span_nxt   (span_nxt)
  );

  // Window classification on the span that is being registered this edge.
  always_comb begin
    good     = (span_nxt <= LOCK_THR);
    bad      = (span_nxt >= UNLOCK_THR);
    good_inc = good_cnt_p1 + 4'd1;
    loss_inc = loss_cnt_p1 + 4'd1;
  end

  // ---- stage p1: lock FSM, stepped only on the edge that closes a window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1    <= UNLOCK;
      good_cnt_p1 <= '0;
      loss_cnt_p1 <= '0;
      locked_p1   <= 1'b0;
    end else if (win_end) begin
      case (state_p1)
        UNLOCK: begin
          if (good) begin
            if (LOCK_WINS == 1) begin
              state_p1    <= LOCKED;
              good_cnt_p1 <= '0;
              locked_p1   <= 1'b1;
            end else begin
              state_p1    <= ACQ;
              good_cnt_p1 <= 4'd1;
            end
            loss_cnt_p1 <= '0;
          end
        end
        ACQ: begin
          if (good) begin
            if (good_inc == 4'(LOCK_WINS)) begin
              state_p1    <= LOCKED;
              good_cnt_p1 <= '0;
              locked_p1   <= 1'b1;
            end else begin
              good_cnt_p1 <= good_inc;
            end
          end else begin
            state_p1    <= UNLOCK;
            good_cnt_p1 <= '0;
          end
          loss_cnt_p1 <= '0;
        end
        LOCKED: begin
          if (bad) begin
            if (loss_inc == 4'(LOSS_WINS)) begin
              state_p1    <= UNLOCK;
              loss_cnt_p1 <= '0;
              locked_p1   <= 1'b0;
            end else begin
              loss_cnt_p1 <= loss_inc;
            end
          end else begin
            loss_cnt_p1 <= '0;
          end
          good_cnt_p1 <= '0;
        end
        default: begin
          state_p1    <= UNLOCK;
          good_cnt_p1 <= '0;
          loss_cnt_p1 <= '0;
          locked_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign lock_state = state_p1;
  assign locked     = locked_p1;

endmodule

// File: doc/lock_detect.md
LOCK_DETECT -- requirements
Module: lock_detect

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10, meaning window length = 2^WIN_LOG2 qualified samples (legal 2..16).
REQ-002 SHALL have parameter LOCK_THR, default 29'd4096, meaning the max df span for a window to count as good.
REQ-003 SHALL have parameter UNLOCK_THR, default 29'd16384, meaning the min df span for a window to count as bad while LOCKED (UNLOCK_THR >= LOCK_THR).
REQ-004 SHALL have parameter LOCK_WINS, default 4, meaning consecutive good windows needed to declare lock (legal 1..15).
REQ-005 SHALL have parameter LOSS_WINS, default 3, meaning consecutive bad windows needed to drop lock (legal 1..15).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, carrier-loop clock domain, 16 MHz.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-008 SHALL have port clken, input, 1 bit: sample qualifier; df is consumed only when clken=1.
REQ-009 SHALL have port df, input, signed 28 bits: the carrier loop-filter output (frequency correction word).
REQ-010 SHALL have port span, output, unsigned 29 bits: max(df)-min(df) of the last completed window.
REQ-011 SHALL have port span_valid, output, 1 bit: one-cycle pulse when span updates.
REQ-012 SHALL have port lock_state, output, 2 bits: 0=UNLOCK, 1=ACQ, 2=LOCKED.
REQ-013 SHALL have port locked, output, 1 bit: high iff lock_state==LOCKED.

Function
REQ-014 SHALL keep a sample counter 0..2^WIN_LOG2-1, advancing only when clken=1, and wrapping to 0 after the last window sample.
REQ-015 SHALL track the running signed min and max of df over the window; the first sample of each window loads both registers directly, with no dependence on the previous window.
REQ-016 SHALL compute span as max-min in 29-bit unsigned arithmetic with no saturation; the full -2^27..2^27-1 range maps exactly.
REQ-017 SHALL, on the clock edge that consumes the last window sample, register span (including that sample), pulse span_valid for exactly one cycle, and update the FSM on the same edge.
REQ-018 SHALL classify a window as good if span <= LOCK_THR, and as bad if span >= UNLOCK_THR; a span strictly between the two is neutral.
REQ-019 SHALL implement these FSM transitions, evaluated only at window end:
  - UNLOCK: good -> ACQ with good count=1; if LOCK_WINS=1, go directly to LOCKED.
  - ACQ: good -> increment count, and go to LOCKED when count reaches LOCK_WINS; neutral or bad -> UNLOCK with count cleared.
  - LOCKED: bad -> increment loss count, and go to UNLOCK when it reaches LOSS_WINS; good or neutral -> loss count cleared.
REQ-020 SHALL hold all state, counters and the min/max registers while clken=0; an idle gap inside a window does not restart it.
REQ-021 SHALL clear both window counts on every state change.
REQ-022 SHALL update locked on the same edge as lock_state, with no extra latency.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously force span=0, span_valid=0, lock_state=UNLOCK, locked=0, all counters=0, and the min/max registers=0.
REQ-024 SHALL treat assertion of reset mid-window as discarding the partial window; the first window after release starts at the first qualified sample.

Structure
REQ-025 SHALL place the lock_state encodings (UNLOCK/ACQ/LOCKED) and the DF_W=28 width constant in a shared package, lock_pkg.
REQ-026 SHALL be implemented as one sub-module, win_span (counter plus min/max/span and the window-end strobe), instantiated by a lock_detect top module that contains the FSM.

Verification (WIN_LOG2=4, LOCK_THR=100, UNLOCK_THR=400, LOCK_WINS=3, LOSS_WINS=2)
REQ-027 SHALL cover: constant df=1000 with clken=1 -> span_valid every 16 cycles with span=0; lock_state goes 1,1,2; locked rises at the 3rd window end.
REQ-028 SHALL cover: while LOCKED, a window alternating df=0/500 (span 500), then one window of span 200, then two windows of span 500 -> stays LOCKED, stays LOCKED, then drops to UNLOCK at the second span-500 window.
REQ-029 SHALL cover: in ACQ after 2 good windows, one window with span 250 -> lock_state=UNLOCK and the good count restarts from 0.
REQ-030 SHALL cover: a window containing df=-2^27 and df=2^27-1 -> span=29'h0FFFFFFF, with no wrap.
REQ-031 SHALL cover: clken toggling 1/0 every cycle -> span_valid every 32 cycles with spans identical to the clken=1 run.
REQ-032 SHALL cover: reset_n pulsed low mid-window while LOCKED -> outputs 0/UNLOCK immediately with no clock edge; the next span_valid occurs 16 qualified samples after release.
